// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer that time-shares one sequential Booth multiplier between NREQ requesters,
// holding operands stable for the whole multiply and guarding the wait with a saturating watchdog.
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int WIDTH   = 10,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  mul_enable,
  output logic [WIDTH-1:0]      mul_data,
  input  logic                  mul_ready,
  input  logic [WIDTH-1:0]      mul_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic [WDW-1:0]   wdog_inc;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              found;
  logic [IDW-1:0]    pick;
  int                pick_i;

  // Rotate the request vector so bit 0 is the requester just after rr_q; lowest set bit wins.
  always_comb begin
    req_dbl = {req, req};
    req_rot = NREQ'(req_dbl >> (int'(rr_q) + 1));
    found   = |req_rot;
    pick_i  = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_rot[j]) pick_i = j;
    end
    pick_i = pick_i + int'(rr_q) + 1;
    if (pick_i >= NREQ) pick_i = pick_i - NREQ;
    pick = IDW'(pick_i);
  end

  assign wdog_inc = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    op_d    = op_q;
    data_d  = data_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          rr_d    = pick;
          id_d    = pick;
          op_d    = req_data[pick*WIDTH +: WIDTH];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_ready) begin
          state_d = S_CAPTURE;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc == WD_LAST) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = S_RESP;
          end
        end
      end
      S_CAPTURE: begin
        // Product appears on mul_out the cycle after the ready pulse.
        data_d  = mul_out;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rr_q    <= IDW'(NREQ - 1);
      id_q    <= '0;
      op_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  // The multiplicand is resampled on every accumulate step, so operands stay up until capture.
  assign mul_data   = (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_CAPTURE) ? op_q : '0;
  assign mul_enable = (state_q == S_ISSUE);
  assign gnt        = (state_q == S_IDLE && found && rst) ? (NREQ'(1) << pick) : '0;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed and randomized bench for mult_share_arbiter with a behavioural multiplier and a
// transaction-level round-robin/product reference model.
module tb_mult_share_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int WIDTH   = 10;
  localparam int TIMEOUT = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       gnt;
  logic                  mul_enable;
  logic [WIDTH-1:0]      mul_data;
  logic                  mul_ready;
  logic [WIDTH-1:0]      mul_out;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
  logic                  busy;

  int nvec = 0;
  int nerr = 0;
  int exp_rr = NREQ - 1;
  int lat_cfg = 2;
  logic hang = 1'b0;
  logic spur = 1'b0;

  logic [7:0]       m_cnt;
  logic             m_rdy;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .mul_enable(mul_enable), .mul_data(mul_data), .mul_ready(mul_ready), .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [WIDTH-1:0] prod(input logic [WIDTH-1:0] d);
    int a, b;
    a = int'($signed(d[9:5]));
    b = int'($signed(d[4:0]));
    return WIDTH'(a * b);
  endfunction

  // Behavioural multiplier: ready lat_cfg cycles after start, product one cycle after ready.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt   <= '0;
      m_rdy   <= 1'b0;
      mul_out <= '0;
    end else begin
      m_rdy <= 1'b0;
      if (mul_enable && !hang) m_cnt <= 8'(lat_cfg);
      else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1'b1;
        if (m_cnt == 1) m_rdy <= 1'b1;
      end
      if (m_rdy) mul_out <= prod(mul_data);
    end
  end
  assign mul_ready = m_rdy | spur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_winner(input logic [NREQ-1:0] snap);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (exp_rr + k) % NREQ;
      if (snap[c]) return c;
    end
    return -1;
  endfunction

  // Serve one job starting at a negedge in IDLE; returns the granted id.
  task automatic serve(input bit keep, input int hold, input bit spur_hold, input bit exp_err,
                       output int gid);
    int k, lat, en, id, exp_lat;
    logic [WIDTH-1:0] op, exp_data;
    k = 0;
    #1;
    while (gnt == '0 && k < 200) begin
      @(negedge clk); #1; k++;
    end
    chk("gnt_seen", 32'(gnt != '0), 32'd1);
    id = rr_winner(req);
    if (id < 0) id = 0;
    gid = id;
    chk("gnt_onehot", 32'(gnt), 32'(1) << id);
    op = req_data[id*WIDTH +: WIDTH];
    exp_rr = id;
    if (hold > 0) rsp_ready = 1'b0;
    @(posedge clk); #1;
    if (!keep) req[id] = 1'b0;
    lat = 0;
    en  = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mul_enable) en++;
    end while (!rsp_valid && lat < 200);
    exp_lat  = exp_err ? TIMEOUT + 1 : lat_cfg + 4;
    exp_data = exp_err ? '0 : prod(op);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("enable_pulses", 32'(en), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_data", 32'(rsp_data), 32'(exp_data));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      if (spur_hold && h == 0) spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'({rsp_id, rsp_err, rsp_data}), 32'({IDW'(id), exp_err, exp_data}));
      chk("hold_nognt", 32'(gnt), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_dropped", 32'({rsp_valid, busy}), 32'd0);
    if (keep) req[id] = 1'b1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  initial begin
    int gid;
    int order[5] = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({gnt, mul_enable, mul_data, rsp_valid, rsp_id, rsp_data, rsp_err, busy}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: single request, 3 * -2
    req_data[0 +: WIDTH] = {5'd3, 5'b11110};
    lat_cfg = 3;
    req = 4'b0001;
    serve(0, 0, 0, 0, gid);
    chk("t1_data", 32'(rsp_data), 32'h3FA);

    // 2: all requesting continuously from reset
    rst = 1'b0; exp_rr = NREQ - 1;
    @(negedge clk); rst = 1'b1;
    rand_data();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      lat_cfg = 1 + n;
      serve(1, 0, 0, 0, gid);
      chk("t2_order", 32'(gid), 32'(order[n]));
    end
    req = '0;

    // 3: hung multiplier, then recovery
    hang = 1'b1;
    req = 4'b0010;
    serve(0, 0, 0, 1, gid);
    hang = 1'b0;
    lat_cfg = 2;
    req = 4'b0010;
    serve(0, 0, 0, 0, gid);

    // 4: backpressure with another requester pending
    rand_data();
    req = 4'b0101;
    serve(0, 5, 0, 0, gid);
    chk("t4_id", 32'(gid), 32'd2);
    chk("t4_next_gnt", 32'(gnt), 32'b0001);
    serve(0, 0, 0, 0, gid);

    // 5: reset during WAIT
    lat_cfg = 10;
    req = 4'b0010;
    #1;
    chk("t5_gnt", 32'(gnt), 32'b0010);
    @(posedge clk); #1; req = '0;
    @(negedge clk); @(negedge clk);
    chk("t5_in_wait", 32'({busy, mul_enable}), 32'b10);
    rst = 1'b0; exp_rr = NREQ - 1;
    #1;
    chk("t5_async_clear", 32'({gnt, mul_enable, mul_data, rsp_valid, rsp_id, rsp_data, rsp_err, busy}), 32'd0);
    @(negedge clk); rst = 1'b1;
    lat_cfg = 2;
    req = 4'b0101;
    serve(0, 0, 0, 0, gid);
    chk("t5_ptr_reset", 32'(gid), 32'd0);
    req = 4'b0100;
    serve(0, 0, 0, 0, gid);
    chk("t5_req2", 32'(gid), 32'd2);

    // 6: spurious ready in IDLE and RESP
    spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    @(negedge clk);
    chk("t6_idle_spur", 32'({busy, rsp_valid}), 32'd0);
    req_data[0 +: WIDTH] = {5'b10000, 5'b10000};
    req = 4'b0001;
    serve(0, 3, 1, 0, gid);
    chk("t6_data", 32'(rsp_data), 32'd256);

    // 7: randomized jobs
    for (int n = 0; n < 30; n++) begin
      if (req == '0) req = NREQ'($urandom_range(1, 15));
      else req = req | NREQ'($urandom_range(0, 15));
      rand_data();
      lat_cfg = $urandom_range(1, 6);
      serve(0, $urandom_range(0, 2), 0, 0, gid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
